// File: rtl/rally_referee.sv
// Volleyball rules controller: touch counting, ground calls, scoring,
// post-point pause and end-of-game detection.
module rally_referee #(
   parameter int NET_X        = 512,
   parameter int WIN_SCORE    = 15,
   parameter int WIN_LEAD     = 2,
   parameter int MAX_TOUCH    = 3,
   parameter int PAUSE_CYCLES = 65000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] ball_posx,
   input  logic [11:0] ball_posy,
   input  logic        pl1_col,
   input  logic        pl2_col,
   input  logic        gnd_col,
   input  logic        start,
   output logic [4:0]  score_player1,
   output logic [4:0]  score_player2,
   output logic        flag_point,
   output logic        serve_side,
   output logic        ball_respawn,
   output logic        endgame,
   output logic        winner
);

   localparam int CW = $clog2(PAUSE_CYCLES + 1);
   localparam int TW = $clog2(MAX_TOUCH + 1);
   localparam logic [CW-1:0] PAUSE_LOAD = CW'(PAUSE_CYCLES - 1);
   localparam logic [TW-1:0] TOUCH_MAX  = TW'(MAX_TOUCH);
   localparam logic [4:0]    SCORE_MAX  = 5'd31;

   typedef enum logic [1:0] {
      SERVE,
      RALLY,
      PAUSE,
      GAME_OVER
   } state_t;

   state_t          state;
   logic [CW-1:0]   pause_cnt;
   logic [TW-1:0]   touch_cnt;
   logic            last_side;

   logic pl1_q, pl2_q, start_q;
   logic pl1_e, pl2_e, start_e;
   logic gnd_r, left_r;

   logic touch_one, touch_side, same_side, fault;
   logic award, award_side;
   logic [4:0] win_pts, lose_pts;
   logic win;

   // Debug-only input; no rule looks at the vertical position.
   logic unused_posy;
   assign unused_posy = ^ball_posy;

   // Register previous levels and turn inputs into registered events.
   always_ff @(posedge clk) begin
      if (rst) begin
         pl1_q   <= 1'b0;
         pl2_q   <= 1'b0;
         start_q <= 1'b0;
         pl1_e   <= 1'b0;
         pl2_e   <= 1'b0;
         start_e <= 1'b0;
         gnd_r   <= 1'b0;
         left_r  <= 1'b0;
      end else begin
         pl1_q   <= pl1_col;
         pl2_q   <= pl2_col;
         start_q <= start;
         pl1_e   <= pl1_col & ~pl1_q;
         pl2_e   <= pl2_col & ~pl2_q;
         start_e <= start & ~start_q;
         gnd_r   <= gnd_col;
         left_r  <= (ball_posx < 12'(NET_X));
      end
   end

   // Decode touches, faults and the side that wins the current point.
   always_comb begin
      touch_one  = pl1_e ^ pl2_e;
      touch_side = pl2_e;
      same_side  = (touch_cnt != '0) && (touch_side == last_side);
      fault      = touch_one && same_side && (touch_cnt == TOUCH_MAX);
      award      = gnd_r || fault;
      award_side = gnd_r ? left_r : ~touch_side;
      win_pts    = serve_side ? score_player2 : score_player1;
      lose_pts   = serve_side ? score_player1 : score_player2;
      win        = ({1'b0, win_pts} >= 6'(WIN_SCORE)) &&
                   ({1'b0, win_pts} >= {1'b0, lose_pts} + 6'(WIN_LEAD));
   end

   // Game state machine with registered score and status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= SERVE;
         pause_cnt     <= '0;
         touch_cnt     <= '0;
         last_side     <= 1'b0;
         score_player1 <= 5'd0;
         score_player2 <= 5'd0;
         flag_point    <= 1'b0;
         serve_side    <= 1'b0;
         ball_respawn  <= 1'b0;
         endgame       <= 1'b0;
         winner        <= 1'b0;
      end else begin
         flag_point   <= 1'b0;
         ball_respawn <= 1'b0;
         unique case (state)
            SERVE: begin
               if (start_e) begin
                  ball_respawn <= 1'b1;
                  touch_cnt    <= '0;
                  state        <= RALLY;
               end
            end
            RALLY: begin
               if (award) begin
                  if (award_side) begin
                     if (score_player2 != SCORE_MAX)
                        score_player2 <= score_player2 + 5'd1;
                  end else begin
                     if (score_player1 != SCORE_MAX)
                        score_player1 <= score_player1 + 5'd1;
                  end
                  flag_point <= 1'b1;
                  serve_side <= award_side;
                  pause_cnt  <= PAUSE_LOAD;
                  state      <= PAUSE;
               end else if (touch_one) begin
                  if (same_side) begin
                     touch_cnt <= touch_cnt + TW'(1);
                  end else begin
                     touch_cnt <= TW'(1);
                     last_side <= touch_side;
                  end
               end
            end
            PAUSE: begin
               if (pause_cnt == '0) begin
                  if (win) begin
                     endgame <= 1'b1;
                     winner  <= serve_side;
                     state   <= GAME_OVER;
                  end else begin
                     state <= SERVE;
                  end
               end else begin
                  pause_cnt <= pause_cnt - CW'(1);
               end
            end
            GAME_OVER: begin
               if (start_e) begin
                  score_player1 <= 5'd0;
                  score_player2 <= 5'd0;
                  endgame       <= 1'b0;
                  winner        <= 1'b0;
                  serve_side    <= 1'b0;
                  state         <= SERVE;
               end
            end
            default: state <= SERVE;
         endcase
      end
   end

endmodule

// File: tb/tb_rally_referee.sv
// Directed bench for rally_referee; a scoreboard queue holds the expected
// scores/serve side for every awarded point.
module tb_rally_referee;

   localparam int PC = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] ball_posx = 12'd0;
   logic [11:0] ball_posy = 12'd0;
   logic        pl1_col = 1'b0;
   logic        pl2_col = 1'b0;
   logic        gnd_col = 1'b0;
   logic        start = 1'b0;
   logic [4:0]  score_player1;
   logic [4:0]  score_player2;
   logic        flag_point;
   logic        serve_side;
   logic        ball_respawn;
   logic        endgame;
   logic        winner;

   typedef struct packed {
      logic [4:0] s1;
      logic [4:0] s2;
      logic       ss;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int checks = 0;
   int errors = 0;
   int flags = 0;
   int exp_flags = 0;
   int resps = 0;

   rally_referee #(.PAUSE_CYCLES(PC)) dut (
      .clk(clk),
      .rst(rst),
      .ball_posx(ball_posx),
      .ball_posy(ball_posy),
      .pl1_col(pl1_col),
      .pl2_col(pl2_col),
      .gnd_col(gnd_col),
      .start(start),
      .score_player1(score_player1),
      .score_player2(score_player2),
      .flag_point(flag_point),
      .serve_side(serve_side),
      .ball_respawn(ball_respawn),
      .endgame(endgame),
      .winner(winner)
   );

   always #5 clk = ~clk;

   // Scoreboard side: every flag_point pops one expected result.
   always @(negedge clk) begin
      if (ball_respawn) resps++;
      if (flag_point) begin
         flags++;
         checks++;
         assert (q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_point observed %0d/%0d expected none",
                   score_player1, score_player2);
         end
         if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            assert ({score_player1, score_player2, serve_side} === e) else begin
               errors++;
               $error("FAIL point_result observed %0d/%0d/%0d expected %0d/%0d/%0d",
                      score_player1, score_player2, serve_side, e.s1, e.s2, e.ss);
            end
         end
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_point(input int s1, input int s2, input bit ss);
      q.push_back(exp_t'{s1: 5'(s1), s2: 5'(s2), ss: ss});
      exp_flags++;
   endtask

   task automatic serve();
      start = 1'b1;
      tick(1);
      start = 1'b0;
      chk("respawn_before", ball_respawn, 0);
      tick(1);
      chk("respawn_pulse", ball_respawn, 1);
      tick(1);
      chk("respawn_after", ball_respawn, 0);
   endtask

   task automatic wait_flag(input string tag);
      int n = 0;
      while (!flag_point && n < 12) begin
         tick(1);
         n++;
      end
      chk(tag, flag_point, 1);
   endtask

   task automatic gnd_point(input int x, input int s1, input int s2, input bit ss);
      expect_point(s1, s2, ss);
      ball_posx = 12'(x);
      gnd_col = 1'b1;
      tick(1);
      gnd_col = 1'b0;
      wait_flag("gnd_flag");
      tick(PC + 1);
   endtask

   task automatic touch(input bit side);
      if (side) pl2_col = 1'b1;
      else pl1_col = 1'b1;
      tick(1);
      pl1_col = 1'b0;
      pl2_col = 1'b0;
      tick(1);
   endtask

   initial begin
      tick(2);
      rst = 1'b0;
      chk("rst_s1", score_player1, 0);
      chk("rst_s2", score_player2, 0);
      chk("rst_flag", flag_point, 0);
      chk("rst_serve", serve_side, 0);
      chk("rst_respawn", ball_respawn, 0);
      chk("rst_endgame", endgame, 0);
      chk("rst_winner", winner, 0);

      // Ground on player 1's half.
      serve();
      gnd_point(300, 0, 1, 1'b1);
      chk("p1_serve_side", serve_side, 1);
      chk("p1_respawn_count", resps, 1);
      chk("p1_flag_count", flags, 1);

      // Four touches by player 1: fault.
      serve();
      chk("p2_respawn_count", resps, 2);
      touch(1'b0);
      touch(1'b0);
      touch(1'b0);
      expect_point(0, 2, 1'b1);
      touch(1'b0);
      wait_flag("fault_flag");
      tick(PC + 1);

      // Three touches then a player 2 touch: legal.
      serve();
      touch(1'b0);
      touch(1'b0);
      touch(1'b0);
      touch(1'b1);
      tick(4);
      chk("legal_no_point", flags, 2);
      gnd_point(700, 1, 2, 1'b0);

      // Ground and fourth player 2 touch together: one point only.
      serve();
      touch(1'b1);
      touch(1'b1);
      touch(1'b1);
      expect_point(2, 2, 1'b0);
      ball_posx = 12'd700;
      pl2_col = 1'b1;
      gnd_col = 1'b1;
      tick(1);
      pl2_col = 1'b0;
      gnd_col = 1'b0;
      wait_flag("simul_flag");
      tick(PC + 1);
      chk("simul_flag_count", flags, 4);
      chk("simul_s1", score_player1, 2);

      // Alternate points up to 14/14.
      for (int i = 0; i < 12; i++) begin
         serve();
         gnd_point(700, 3 + i, 2 + i, 1'b0);
         serve();
         gnd_point(300, 3 + i, 3 + i, 1'b1);
      end
      serve();
      gnd_point(700, 15, 14, 1'b0);
      chk("lead1_endgame", endgame, 0);
      serve();
      gnd_point(700, 16, 14, 1'b0);
      chk("win_endgame", endgame, 1);
      chk("win_winner", winner, 0);
      chk("win_hold_s1", score_player1, 16);
      chk("win_hold_s2", score_player2, 14);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(1);
      chk("restart_s1", score_player1, 0);
      chk("restart_s2", score_player2, 0);
      chk("restart_endgame", endgame, 0);
      chk("restart_serve", serve_side, 0);

      // Reset during the pause at 3/2.
      tick(2);
      serve();
      gnd_point(700, 1, 0, 1'b0);
      serve();
      gnd_point(300, 1, 1, 1'b1);
      serve();
      gnd_point(700, 2, 1, 1'b0);
      serve();
      gnd_point(300, 2, 2, 1'b1);
      serve();
      expect_point(3, 2, 1'b0);
      ball_posx = 12'd700;
      gnd_col = 1'b1;
      tick(1);
      gnd_col = 1'b0;
      wait_flag("pre_rst_flag");
      tick(3);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("midrst_s1", score_player1, 0);
      chk("midrst_s2", score_player2, 0);
      chk("midrst_flag", flag_point, 0);
      chk("midrst_serve", serve_side, 0);
      tick(3);
      chk("midrst_flag_later", flag_point, 0);
      serve();
      gnd_point(700, 1, 0, 1'b0);

      chk("queue_empty", q.size(), 0);
      chk("flag_total", flags, exp_flags);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
